flash_cmd_seq: RTL and testbench
================================

// Module: flash_cmd_seq
// PURPOSE
//  Command sequencer above flash_int. Turns one user request (read word, program word,
//  erase block) into the StrataFlash bus-cycle sequence: unlock, command/confirm, status
//  poll, clear-status, return to read-array. Drives flash_int's op/address/wdata port;
//  sole owner of that port. Reports read data, final status register and error flags.
// PARAMETERS
//  POLL_LIMIT   20'd1000000  max status reads per program/erase before timeout
//  BLOCK_MASK   23'h7F0000   address bits kept for block-level cmds (64 KW blocks)
// PORTS
//  clock     in   1   system clock
//  reset     in   1   asynchronous, active-high reset
//  start     in   1   1-cycle request strobe; honoured only while ready=1
//  cmd       in   2   00 NOP, 01 READ, 10 PROGRAM, 11 ERASE; sampled with start
//  addr      in   23  word address, sampled with start
//  wdata     in   16  program data, sampled with start
//  ready     out  1   idle, accepts start
//  done      out  1   1-cycle pulse when request finishes
//  rdata     out  16  READ result, valid from done until next start
//  status    out  8   last status register read (PROGRAM/ERASE)
//  err       out  1   device error: status[5]|status[4]|status[3]|status[1]
//  timeout   out  1   poll count reached POLL_LIMIT
//  f_op      out  2   to flash_int op (00 idle, 01 read, 10 write)
//  f_addr    out  23  to flash_int address
//  f_wdata   out  16  to flash_int wdata
//  f_busy    in   1   from flash_int busy
//  f_rdata   in   16  from flash_int rdata
// BEHAVIOUR
//  Reset (async): state IDLE; ready=0 until f_busy first low, then 1; done=0; rdata=0;
//   status=0; err=0; timeout=0; f_op=00; f_addr=0; f_wdata=0; poll counter=0.
//  Micro-op handshake: ISSUE holds f_op/f_addr/f_wdata for exactly one cycle in which
//   f_busy=0, then f_op=00; WAIT_HI until f_busy=1; WAIT_LO until f_busy=0; micro-op done
//   (read data taken from f_rdata that cycle). f_op never nonzero while f_busy=1.
//  start with ready=1 latches cmd/addr/wdata, clears err/timeout, ready->0 next cycle.
//   cmd=NOP: done pulses next cycle, nothing issued. start while ready=0 is ignored.
//  Sequences (W=write, R=read; B = addr & BLOCK_MASK):
//   READ:    W FF@addr; R @addr -> rdata.
//   PROGRAM: W 60@B; W D0@B; W 40@addr; W wdata@addr; POLL; [W 50@B]; W FF@B.
//   ERASE:   W 60@B; W D0@B; W 20@B; W D0@B; POLL; [W 50@B]; W FF@B.
//  POLL: R @B repeatedly; status<=f_rdata[7:0] each read; exit when bit7=1. Counter ++ per
//   read; on reaching POLL_LIMIT: timeout=1, exit. err evaluated on exit.
//  W 50 (clear status) issued only if err=1 or timeout=1; W FF always last.
//  done pulses the cycle after final micro-op completes; ready=1 same cycle.
//  Reset mid-sequence: abort immediately to reset values; flash_int is reset on the same
//   reset, so no partial op is resumed.
//  err/timeout/status/rdata held until next accepted start.
// STRUCTURE
//  flash_pkg: FLASHOP_IDLE/READ/WRITE, CMD_NOP/READ/PROGRAM/ERASE codes, flash command
//   bytes (FF,60,D0,40,20,70,50), status bit indices.
//  Sub-module flash_op_issuer: one-micro-op handshake (ISSUE/WAIT_HI/WAIT_LO) with
//   go/op/addr/data in, ack + captured rdata out. Top FSM: IDLE, STEP(n), POLL, FINISH.
// TESTING (flash_int + behavioural StrataFlash model)
//  READ addr 0x001234, model word 0xBEEF -> bus writes FF then read; rdata=0xBEEF, done 1 cyc.
//  PROGRAM 0x000010 data 0x5A5A, SR7 set after 3 polls -> 60,D0,40,5A5A,3 reads,FF; err=0.
//  ERASE 0x012345, model reports SR=0xA0 -> ops 60,D0,20,D0 @0x010000; err=1; 50 then FF.
//  POLL_LIMIT=4, SR7 never set -> exactly 4 polls, timeout=1, 50 and FF issued, done.
//  start while ready=0 and reset asserted mid-ERASE -> ignored / all outputs to reset vals.
//  Assert every cycle: f_op!=00 only when f_busy=0, and for one cycle per micro-op.

Source files
------------

// File: rtl/flash_cmd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : flash_cmd_seq_pkg
// Brief   : Shared codes for the StrataFlash command sequencer: flash_int op
//           codes, user command codes, flash command bytes, status bits,
//           FSM state types and the per-step micro-op decoder.
// Revision: 1.0  initial release
// ============================================================================
package flash_cmd_seq_pkg;

    // flash_int op codes
    localparam logic [1:0] FLASHOP_IDLE  = 2'b00;
    localparam logic [1:0] FLASHOP_READ  = 2'b01;
    localparam logic [1:0] FLASHOP_WRITE = 2'b10;

    // user request codes
    localparam logic [1:0] CMD_NOP     = 2'b00;
    localparam logic [1:0] CMD_READ    = 2'b01;
    localparam logic [1:0] CMD_PROGRAM = 2'b10;
    localparam logic [1:0] CMD_ERASE   = 2'b11;

    // StrataFlash command bytes
    localparam logic [7:0] FCMD_READ_ARRAY   = 8'hFF;
    localparam logic [7:0] FCMD_UNLOCK_SETUP = 8'h60;
    localparam logic [7:0] FCMD_CONFIRM      = 8'hD0;
    localparam logic [7:0] FCMD_PROGRAM      = 8'h40;
    localparam logic [7:0] FCMD_ERASE        = 8'h20;
    localparam logic [7:0] FCMD_CLEAR_STATUS = 8'h50;

    // status register bit indices
    localparam int SR_READY     = 7;
    localparam int SR_ERASE_ERR = 5;
    localparam int SR_PROG_ERR  = 4;
    localparam int SR_VPP_ERR   = 3;
    localparam int SR_LOCK_ERR  = 1;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_STEP,
        SEQ_POLL,
        SEQ_FINISH
    } seq_state_t;

    typedef enum logic [1:0] {
        ISS_IDLE,
        ISS_ISSUE,
        ISS_WAIT_HI,
        ISS_WAIT_LO
    } iss_state_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [22:0] addr;
        logic [15:0] data;
    } micro_op_t;

    // Any device-reported failure bit in a status byte
    function automatic logic sr_error(input logic [7:0] sr);
        return sr[SR_ERASE_ERR] | sr[SR_PROG_ERR] | sr[SR_VPP_ERR] | sr[SR_LOCK_ERR];
    endfunction

    // Fixed (non-poll) micro-op for a given command and step index.
    // Steps 0-3 are the setup writes (READ uses only 0-1), step 4 is the
    // conditional clear-status and step 5 the final return to read-array.
    function automatic micro_op_t seq_step(
        input logic [1:0]  cmd,
        input logic [2:0]  step,
        input logic [22:0] addr,
        input logic [22:0] blk,
        input logic [15:0] wdata
    );
        micro_op_t m;
        m.op   = FLASHOP_WRITE;
        m.addr = blk;
        m.data = {8'h00, FCMD_READ_ARRAY};
        case (step)
            3'd0: begin
                if (cmd == CMD_READ) m.addr = addr;
                else                 m.data = {8'h00, FCMD_UNLOCK_SETUP};
            end
            3'd1: begin
                if (cmd == CMD_READ) begin
                    m.op   = FLASHOP_READ;
                    m.addr = addr;
                    m.data = 16'h0000;
                end else begin
                    m.data = {8'h00, FCMD_CONFIRM};
                end
            end
            3'd2: begin
                if (cmd == CMD_PROGRAM) begin
                    m.addr = addr;
                    m.data = {8'h00, FCMD_PROGRAM};
                end else begin
                    m.data = {8'h00, FCMD_ERASE};
                end
            end
            3'd3: begin
                if (cmd == CMD_PROGRAM) begin
                    m.addr = addr;
                    m.data = wdata;
                end else begin
                    m.data = {8'h00, FCMD_CONFIRM};
                end
            end
            3'd4:    m.data = {8'h00, FCMD_CLEAR_STATUS};
            default: m.data = {8'h00, FCMD_READ_ARRAY};
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flash_cmd_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : flash_cmd_seq_if
// Brief   : User-side request/response bundle of the flash command sequencer.
//           master = requester, slave = sequencer.
// Revision: 1.0  initial release
// ============================================================================
interface flash_cmd_seq_if;
    logic        start;
    logic [1:0]  cmd;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic        ready;
    logic        done;
    logic [15:0] rdata;
    logic [7:0]  status;
    logic        err;
    logic        timeout;

    modport master (
        output start, cmd, addr, wdata,
        input  ready, done, rdata, status, err, timeout
    );

    modport slave (
        input  start, cmd, addr, wdata,
        output ready, done, rdata, status, err, timeout
    );
endinterface
`default_nettype wire

// File: rtl/flash_cmd_seq_issuer.sv
`default_nettype none
// ============================================================================
// Module  : flash_cmd_seq_issuer
// Brief   : Runs one flash_int micro-op: presents op for exactly one cycle
//           with busy low, waits for busy to rise then fall, then acks.
//           Read data is valid on rdata in the ack cycle.
// Revision: 1.0  initial release
// ============================================================================
module flash_cmd_seq_issuer
    import flash_cmd_seq_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        go,
    input  logic [1:0]  op,
    input  logic [22:0] addr,
    input  logic [15:0] data,
    output logic        ack,
    output logic [15:0] rdata,
    output logic [1:0]  f_op,
    output logic [22:0] f_addr,
    output logic [15:0] f_wdata,
    input  logic        f_busy,
    input  logic [15:0] f_rdata
);

    iss_state_t  r_state;
    iss_state_t  w_state_nxt;
    logic [1:0]  r_op;
    logic [22:0] r_addr;
    logic [15:0] r_data;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ISS_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Hold the micro-op fields from go until the next go
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_op   <= FLASHOP_IDLE;
            r_addr <= '0;
            r_data <= '0;
        end else if (go && (r_state == ISS_IDLE)) begin
            r_op   <= op;
            r_addr <= addr;
            r_data <= data;
        end
    end

    // Handshake sequencing; op is gated by busy so it never overlaps a busy flash_int
    always_comb begin
        w_state_nxt = r_state;
        f_op        = FLASHOP_IDLE;
        ack         = 1'b0;
        case (r_state)
            ISS_IDLE:    if (go) w_state_nxt = ISS_ISSUE;
            ISS_ISSUE: begin
                if (!f_busy) begin
                    f_op        = r_op;
                    w_state_nxt = ISS_WAIT_HI;
                end
            end
            ISS_WAIT_HI: if (f_busy) w_state_nxt = ISS_WAIT_LO;
            ISS_WAIT_LO: begin
                if (!f_busy) begin
                    ack         = 1'b1;
                    w_state_nxt = ISS_IDLE;
                end
            end
            default:     w_state_nxt = ISS_IDLE;
        endcase
    end

    assign f_addr  = r_addr;
    assign f_wdata = r_data;
    assign rdata   = f_rdata;

endmodule
`default_nettype wire

// File: rtl/flash_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module  : flash_cmd_seq
// Brief   : Turns one user request (read / program / erase) into the
//           StrataFlash bus-cycle sequence on flash_int, polls status,
//           clears status on failure and returns the device to read-array.
// Revision: 1.0  initial release
// ============================================================================
module flash_cmd_seq
    import flash_cmd_seq_pkg::*;
#(
    parameter logic [19:0] POLL_LIMIT = 20'd1000000,
    parameter logic [22:0] BLOCK_MASK = 23'h7F0000
) (
    input  logic           clock,
    input  logic           reset,
    flash_cmd_seq_if.slave bus,
    output logic [1:0]     f_op,
    output logic [22:0]    f_addr,
    output logic [15:0]    f_wdata,
    input  logic           f_busy,
    input  logic [15:0]    f_rdata
);

    seq_state_t  r_state;
    seq_state_t  w_state_nxt;
    logic        r_armed;
    logic [1:0]  r_cmd;
    logic [22:0] r_addr;
    logic [15:0] r_wdata;
    logic [2:0]  r_step;
    logic        r_wait;
    logic [19:0] r_poll_cnt;
    logic        r_done;
    logic [15:0] r_rdata;
    logic [7:0]  r_status;
    logic        r_err;
    logic        r_timeout;

    logic        w_ready;
    logic        w_accept;
    logic        w_go;
    logic        w_ack;
    logic        w_last;
    logic        w_to_poll;
    logic        w_poll_limit;
    logic        w_poll_exit;
    logic        w_exit_err;
    logic [19:0] w_poll_cnt_inc;
    logic [22:0] w_blk;
    logic [15:0] w_iss_rdata;
    micro_op_t   w_step_op;
    micro_op_t   w_go_op;

    assign w_blk          = r_addr & BLOCK_MASK;
    assign w_step_op      = seq_step(r_cmd, r_step, r_addr, w_blk, r_wdata);
    assign w_go_op        = (r_state == SEQ_POLL) ? micro_op_t'{FLASHOP_READ, w_blk, 16'h0000}
                                                  : w_step_op;
    assign w_accept       = w_ready && bus.start;
    assign w_go           = ((r_state == SEQ_STEP) || (r_state == SEQ_POLL)) && !r_wait;
    assign w_last         = (r_state == SEQ_STEP) && w_ack &&
                            (((r_cmd == CMD_READ) && (r_step == 3'd1)) || (r_step == 3'd5));
    assign w_to_poll      = (r_state == SEQ_STEP) && w_ack && (r_cmd != CMD_READ) && (r_step == 3'd3);
    assign w_poll_cnt_inc = r_poll_cnt + 20'd1;
    assign w_poll_limit   = (w_poll_cnt_inc == POLL_LIMIT);
    assign w_poll_exit    = (r_state == SEQ_POLL) && w_ack && (w_iss_rdata[SR_READY] || w_poll_limit);
    assign w_exit_err     = sr_error(w_iss_rdata[7:0]);

    flash_cmd_seq_issuer u_issuer (
        .clock   (clock),
        .reset   (reset),
        .go      (w_go),
        .op      (w_go_op.op),
        .addr    (w_go_op.addr),
        .data    (w_go_op.data),
        .ack     (w_ack),
        .rdata   (w_iss_rdata),
        .f_op    (f_op),
        .f_addr  (f_addr),
        .f_wdata (f_wdata),
        .f_busy  (f_busy),
        .f_rdata (f_rdata)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= SEQ_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and ready; NOP detours through FINISH so done precedes ready
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = (r_state == SEQ_IDLE) && r_armed;
        case (r_state)
            SEQ_IDLE: begin
                if (w_ready && bus.start)
                    w_state_nxt = (bus.cmd == CMD_NOP) ? SEQ_FINISH : SEQ_STEP;
            end
            SEQ_STEP: begin
                if (w_last)         w_state_nxt = SEQ_IDLE;
                else if (w_to_poll) w_state_nxt = SEQ_POLL;
            end
            SEQ_POLL:   if (w_poll_exit) w_state_nxt = SEQ_STEP;
            SEQ_FINISH: w_state_nxt = SEQ_IDLE;
            default:    w_state_nxt = SEQ_IDLE;
        endcase
    end

    // Request latch, step/poll bookkeeping and result registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_armed    <= 1'b0;
            r_cmd      <= CMD_NOP;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_step     <= '0;
            r_wait     <= 1'b0;
            r_poll_cnt <= '0;
            r_done     <= 1'b0;
            r_rdata    <= '0;
            r_status   <= '0;
            r_err      <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (!f_busy) r_armed <= 1'b1;
            r_done <= (w_accept && (bus.cmd == CMD_NOP)) || w_last;

            if (w_go)       r_wait <= 1'b1;
            else if (w_ack) r_wait <= 1'b0;

            if (w_accept) begin
                r_cmd      <= bus.cmd;
                r_addr     <= bus.addr;
                r_wdata    <= bus.wdata;
                r_step     <= '0;
                r_poll_cnt <= '0;
                r_err      <= 1'b0;
                r_timeout  <= 1'b0;
            end

            if ((r_state == SEQ_STEP) && w_ack) begin
                r_step <= r_step + 3'd1;
                if ((r_cmd == CMD_READ) && (r_step == 3'd1)) r_rdata <= w_iss_rdata;
            end

            if ((r_state == SEQ_POLL) && w_ack) begin
                r_status   <= w_iss_rdata[7:0];
                r_poll_cnt <= w_poll_cnt_inc;
                if (w_poll_exit) begin
                    r_err     <= w_exit_err;
                    r_timeout <= !w_iss_rdata[SR_READY];
                    // clear-status only when something went wrong
                    r_step    <= (w_exit_err || !w_iss_rdata[SR_READY]) ? 3'd4 : 3'd5;
                end
            end
        end
    end

    assign bus.ready   = w_ready;
    assign bus.done    = r_done;
    assign bus.rdata   = r_rdata;
    assign bus.status  = r_status;
    assign bus.err     = r_err;
    assign bus.timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_flash_cmd_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_flash_cmd_seq
// Brief   : Directed bench for flash_cmd_seq with a behavioural flash_int /
//           StrataFlash model that logs every micro-op.
// Revision: 1.0  initial release
// ============================================================================
module tb_flash_cmd_seq;

    typedef struct packed {
        logic [1:0]  op;
        logic [22:0] a;
        logic [15:0] d;
    } rec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  f_op;
    logic [22:0] f_addr;
    logic [15:0] f_wdata;
    logic        f_busy;
    logic [15:0] f_rdata;

    int total = 0;
    int bad   = 0;

    flash_cmd_seq_if bus ();

    flash_cmd_seq #(
        .POLL_LIMIT (20'd4),
        .BLOCK_MASK (23'h7F0000)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .f_op    (f_op),
        .f_addr  (f_addr),
        .f_wdata (f_wdata),
        .f_busy  (f_busy),
        .f_rdata (f_rdata)
    );

    always #5 clock = ~clock;

    // flash_int + device model: busy for 2 cycles per op, status mode after any non-FF write
    rec_t       log_q[$];
    int         m_cnt;
    int         m_sreads;
    int         m_ready_on = 0;
    logic [7:0] m_sr = 8'h00;
    logic       m_stat;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            f_busy   <= 1'b0;
            f_rdata  <= 16'h0000;
            m_cnt    <= 0;
            m_stat   <= 1'b0;
            m_sreads <= 0;
        end else if (f_op != 2'b00) begin
            log_q.push_back({f_op, f_addr, (f_op == 2'b10) ? f_wdata : 16'h0000});
            f_busy <= 1'b1;
            m_cnt  <= 2;
            if (f_op == 2'b10) begin
                m_stat   <= (f_wdata[7:0] != 8'hFF);
                m_sreads <= 0;
            end else if (m_stat) begin
                m_sreads <= m_sreads + 1;
                f_rdata  <= (m_ready_on > 0 && m_sreads + 1 >= m_ready_on) ? {8'h00, m_sr} : 16'h0000;
            end else begin
                f_rdata <= (f_addr == 23'h001234) ? 16'hBEEF : f_addr[15:0];
            end
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) f_busy <= 1'b0;
        end
    end

    // Bus-protocol watch: op only while idle, and never two cycles in a row
    int         prot_viol = 0;
    logic [1:0] prev_op   = 2'b00;
    always @(negedge clock) begin
        if (!reset && (f_op != 2'b00) && (f_busy || (prev_op != 2'b00)))
            prot_viol <= prot_viol + 1;
        prev_op <= f_op;
    end

    function automatic rec_t mk(input logic [1:0] op, input logic [22:0] a, input logic [15:0] d);
        return {op, a, d};
    endfunction

    // Issue one request and wait (bounded) for done
    task automatic run_req(input logic [1:0] c, input logic [22:0] a, input logic [15:0] d,
                           output bit got, output int lat, output logic rdy_at_done,
                           output logic done_after);
        int n;
        got = 0; lat = 0; rdy_at_done = 1'b0; done_after = 1'b0;
        n = 0;
        while (bus.ready !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        log_q.delete();
        bus.start = 1'b1; bus.cmd = c; bus.addr = a; bus.wdata = d;
        @(negedge clock);
        bus.start = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            if (bus.done === 1'b1) begin
                got = 1; lat = i; rdy_at_done = bus.ready;
                break;
            end
            @(negedge clock);
        end
        @(negedge clock);
        done_after = bus.done;
    endtask

    task automatic test_reset;
        bus.start = 1'b0; bus.cmd = 2'b00; bus.addr = '0; bus.wdata = '0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        total++; if (bus.ready   !== 1'b0)  begin bad++; $display("FAIL reset_ready: got %b want 0", bus.ready); end
        total++; if (bus.done    !== 1'b0)  begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        total++; if (bus.rdata   !== 16'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
        total++; if (bus.status  !== 8'h0)  begin bad++; $display("FAIL reset_status: got %h want 0", bus.status); end
        total++; if (bus.err     !== 1'b0)  begin bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
        total++; if (bus.timeout !== 1'b0)  begin bad++; $display("FAIL reset_timeout: got %b want 0", bus.timeout); end
        total++; if (f_op        !== 2'b00) begin bad++; $display("FAIL reset_f_op: got %b want 00", f_op); end
        total++; if (f_addr      !== 23'h0) begin bad++; $display("FAIL reset_f_addr: got %h want 0", f_addr); end
        total++; if (f_wdata     !== 16'h0) begin bad++; $display("FAIL reset_f_wdata: got %h want 0", f_wdata); end
        reset = 1'b0;
        @(negedge clock);
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset: got %b want 1", bus.ready); end
    endtask

    task automatic test_read;
        bit got; int lat; logic rdy, dafter;
        run_req(2'b01, 23'h001234, 16'h0000, got, lat, rdy, dafter);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL read_done: got %b want 1", got); end
        total++; if (log_q.size() != 2) begin bad++; $display("FAIL read_opcount: got %0d want 2", log_q.size()); end
        total++; if (log_q.size() < 1 || log_q[0] !== mk(2'b10, 23'h001234, 16'h00FF))
            begin bad++; $display("FAIL read_op0: got %h want %h", (log_q.size() > 0) ? log_q[0] : '0, mk(2'b10, 23'h001234, 16'h00FF)); end
        total++; if (log_q.size() < 2 || log_q[1] !== mk(2'b01, 23'h001234, 16'h0000))
            begin bad++; $display("FAIL read_op1: got %h want %h", (log_q.size() > 1) ? log_q[1] : '0, mk(2'b01, 23'h001234, 16'h0000)); end
        total++; if (bus.rdata !== 16'hBEEF) begin bad++; $display("FAIL read_rdata: got %h want beef", bus.rdata); end
        total++; if (rdy !== 1'b1)    begin bad++; $display("FAIL read_ready_at_done: got %b want 1", rdy); end
        total++; if (dafter !== 1'b0) begin bad++; $display("FAIL read_done_width: got %b want 0", dafter); end
    endtask

    task automatic test_program;
        bit got; int lat; logic rdy, dafter;
        rec_t exp_ops [8];
        exp_ops = '{mk(2'b10, 23'h0, 16'h0060), mk(2'b10, 23'h0, 16'h00D0),
                    mk(2'b10, 23'h10, 16'h0040), mk(2'b10, 23'h10, 16'h5A5A),
                    mk(2'b01, 23'h0, 16'h0), mk(2'b01, 23'h0, 16'h0),
                    mk(2'b01, 23'h0, 16'h0), mk(2'b10, 23'h0, 16'h00FF)};
        m_ready_on = 3; m_sr = 8'h80;
        run_req(2'b10, 23'h000010, 16'h5A5A, got, lat, rdy, dafter);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL prog_done: got %b want 1", got); end
        total++; if (log_q.size() != 8) begin bad++; $display("FAIL prog_opcount: got %0d want 8", log_q.size()); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (i >= log_q.size()) begin bad++; $display("FAIL prog_op%0d: got none want %h", i, exp_ops[i]); end
            else if (log_q[i] !== exp_ops[i]) begin bad++; $display("FAIL prog_op%0d: got %h want %h", i, log_q[i], exp_ops[i]); end
        end
        total++; if (bus.status  !== 8'h80) begin bad++; $display("FAIL prog_status: got %h want 80", bus.status); end
        total++; if (bus.err     !== 1'b0)  begin bad++; $display("FAIL prog_err: got %b want 0", bus.err); end
        total++; if (bus.timeout !== 1'b0)  begin bad++; $display("FAIL prog_timeout: got %b want 0", bus.timeout); end
    endtask

    task automatic test_erase;
        bit got; int lat; logic rdy, dafter;
        rec_t exp_ops [7];
        exp_ops = '{mk(2'b10, 23'h010000, 16'h0060), mk(2'b10, 23'h010000, 16'h00D0),
                    mk(2'b10, 23'h010000, 16'h0020), mk(2'b10, 23'h010000, 16'h00D0),
                    mk(2'b01, 23'h010000, 16'h0),
                    mk(2'b10, 23'h010000, 16'h0050), mk(2'b10, 23'h010000, 16'h00FF)};
        m_ready_on = 1; m_sr = 8'hA0;
        run_req(2'b11, 23'h012345, 16'h0000, got, lat, rdy, dafter);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL erase_done: got %b want 1", got); end
        total++; if (log_q.size() != 7) begin bad++; $display("FAIL erase_opcount: got %0d want 7", log_q.size()); end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (i >= log_q.size()) begin bad++; $display("FAIL erase_op%0d: got none want %h", i, exp_ops[i]); end
            else if (log_q[i] !== exp_ops[i]) begin bad++; $display("FAIL erase_op%0d: got %h want %h", i, log_q[i], exp_ops[i]); end
        end
        total++; if (bus.status  !== 8'hA0) begin bad++; $display("FAIL erase_status: got %h want a0", bus.status); end
        total++; if (bus.err     !== 1'b1)  begin bad++; $display("FAIL erase_err: got %b want 1", bus.err); end
        total++; if (bus.timeout !== 1'b0)  begin bad++; $display("FAIL erase_timeout: got %b want 0", bus.timeout); end
    endtask

    task automatic test_timeout;
        bit got; int lat; logic rdy, dafter;
        rec_t exp_ops [10];
        exp_ops = '{mk(2'b10, 23'h7F0000, 16'h0060), mk(2'b10, 23'h7F0000, 16'h00D0),
                    mk(2'b10, 23'h7F0000, 16'h0020), mk(2'b10, 23'h7F0000, 16'h00D0),
                    mk(2'b01, 23'h7F0000, 16'h0), mk(2'b01, 23'h7F0000, 16'h0),
                    mk(2'b01, 23'h7F0000, 16'h0), mk(2'b01, 23'h7F0000, 16'h0),
                    mk(2'b10, 23'h7F0000, 16'h0050), mk(2'b10, 23'h7F0000, 16'h00FF)};
        m_ready_on = 0; m_sr = 8'h00;
        run_req(2'b11, 23'h7F1234, 16'h0000, got, lat, rdy, dafter);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL tmo_done: got %b want 1", got); end
        total++; if (log_q.size() != 10) begin bad++; $display("FAIL tmo_opcount: got %0d want 10", log_q.size()); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (i >= log_q.size()) begin bad++; $display("FAIL tmo_op%0d: got none want %h", i, exp_ops[i]); end
            else if (log_q[i] !== exp_ops[i]) begin bad++; $display("FAIL tmo_op%0d: got %h want %h", i, log_q[i], exp_ops[i]); end
        end
        total++; if (bus.timeout !== 1'b1) begin bad++; $display("FAIL tmo_flag: got %b want 1", bus.timeout); end
        total++; if (bus.err     !== 1'b0) begin bad++; $display("FAIL tmo_err: got %b want 0", bus.err); end
    endtask

    task automatic test_nop;
        bit got; int lat; logic rdy, dafter;
        run_req(2'b00, 23'h000055, 16'h0000, got, lat, rdy, dafter);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL nop_done: got %b want 1", got); end
        total++; if (lat != 1)     begin bad++; $display("FAIL nop_latency: got %0d want 1", lat); end
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL nop_ready_at_done: got %b want 0", rdy); end
        total++; if (dafter !== 1'b0) begin bad++; $display("FAIL nop_done_width: got %b want 0", dafter); end
        total++; if (log_q.size() != 0) begin bad++; $display("FAIL nop_opcount: got %0d want 0", log_q.size()); end
        total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL nop_clears_timeout: got %b want 0", bus.timeout); end
        total++; if (bus.rdata !== 16'hBEEF) begin bad++; $display("FAIL nop_rdata_held: got %h want beef", bus.rdata); end
    endtask

    task automatic test_ignored_start;
        bit got;
        got = 0;
        m_ready_on = 3; m_sr = 8'h80;
        log_q.delete();
        bus.start = 1'b1; bus.cmd = 2'b10; bus.addr = 23'h000010; bus.wdata = 16'h1111;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (3) @(negedge clock);
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL busy_ready: got %b want 0", bus.ready); end
        bus.start = 1'b1; bus.cmd = 2'b01; bus.addr = 23'h001234; bus.wdata = 16'h0000;
        @(negedge clock);
        bus.start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bus.done === 1'b1) begin got = 1; break; end
            @(negedge clock);
        end
        total++; if (got !== 1'b1) begin bad++; $display("FAIL ign_done: got %b want 1", got); end
        total++; if (log_q.size() != 8) begin bad++; $display("FAIL ign_opcount: got %0d want 8", log_q.size()); end
        total++; if (log_q.size() < 4 || log_q[3] !== mk(2'b10, 23'h10, 16'h1111))
            begin bad++; $display("FAIL ign_data_op: got %h want %h", (log_q.size() > 3) ? log_q[3] : '0, mk(2'b10, 23'h10, 16'h1111)); end
        total++; if (bus.rdata !== 16'hBEEF) begin bad++; $display("FAIL ign_rdata: got %h want beef", bus.rdata); end
        @(negedge clock);
    endtask

    task automatic test_reset_mid;
        bit got; int lat; logic rdy, dafter;
        m_ready_on = 0; m_sr = 8'h00;
        bus.start = 1'b1; bus.cmd = 2'b11; bus.addr = 23'h7F1234; bus.wdata = 16'h0000;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (12) @(negedge clock);
        reset = 1'b1;
        #1;
        total++; if (bus.ready   !== 1'b0)  begin bad++; $display("FAIL mid_ready: got %b want 0", bus.ready); end
        total++; if (bus.done    !== 1'b0)  begin bad++; $display("FAIL mid_done: got %b want 0", bus.done); end
        total++; if (bus.rdata   !== 16'h0) begin bad++; $display("FAIL mid_rdata: got %h want 0", bus.rdata); end
        total++; if (bus.status  !== 8'h0)  begin bad++; $display("FAIL mid_status: got %h want 0", bus.status); end
        total++; if (bus.err     !== 1'b0)  begin bad++; $display("FAIL mid_err: got %b want 0", bus.err); end
        total++; if (bus.timeout !== 1'b0)  begin bad++; $display("FAIL mid_timeout: got %b want 0", bus.timeout); end
        total++; if (f_op        !== 2'b00) begin bad++; $display("FAIL mid_f_op: got %b want 00", f_op); end
        total++; if (f_addr      !== 23'h0) begin bad++; $display("FAIL mid_f_addr: got %h want 0", f_addr); end
        total++; if (f_wdata     !== 16'h0) begin bad++; $display("FAIL mid_f_wdata: got %h want 0", f_wdata); end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        run_req(2'b01, 23'h001234, 16'h0000, got, lat, rdy, dafter);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL recover_done: got %b want 1", got); end
        total++; if (log_q.size() != 2) begin bad++; $display("FAIL recover_opcount: got %0d want 2", log_q.size()); end
        total++; if (bus.rdata !== 16'hBEEF) begin bad++; $display("FAIL recover_rdata: got %h want beef", bus.rdata); end
    endtask

    task automatic test_protocol;
        total++;
        if (prot_viol != 0) begin bad++; $display("FAIL bus_protocol: got %0d violations want 0", prot_viol); end
    endtask

    initial begin
        test_reset;
        test_read;
        test_program;
        test_erase;
        test_timeout;
        test_nop;
        test_ignored_start;
        test_reset_mid;
        test_protocol;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
